// File: rtl/bp_pkg.sv
// Shared types and helpers for the branch predictor.
// Counter encoding, BTB entry layout and saturating counter arithmetic.
// Optional build macro BP_GSHARE_EN (used by branch_predictor) does not affect this file.
package bp_pkg;

  // Widest tag the 30 word-address bits of a PC can supply; narrower tags
  // are zero-extended into this field.
  localparam int unsigned TAG_MAX = 30;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_t;

  typedef struct packed {
    logic               valid;
    logic [TAG_MAX-1:0] tag;
    logic [31:0]        target;
    ctr_t               ctr;
  } bp_entry_t;

  // Counter value after reset, and the value a freshly allocated entry gets.
  localparam ctr_t CTR_RESET = WNT;
  localparam ctr_t CTR_ALLOC = WT;

  function automatic ctr_t sat_inc(input ctr_t c);
    case (c)
      SNT:     sat_inc = WNT;
      WNT:     sat_inc = WT;
      default: sat_inc = ST;
    endcase
  endfunction

  function automatic ctr_t sat_dec(input ctr_t c);
    case (c)
      ST:      sat_dec = WT;
      WT:      sat_dec = WNT;
      default: sat_dec = SNT;
    endcase
  endfunction

endpackage

// File: rtl/bp_table.sv
// Predictor entry array: two asynchronous read ports (Fetch lookup and
// Decode training read) and one synchronous write port. Reset clears every
// valid bit and returns every counter to CTR_RESET; tags and targets are
// left alone because they are meaningless while valid is low.
// Optional build macro BP_GSHARE_EN (used by branch_predictor) does not affect this file.
module bp_table
  import bp_pkg::*;
#(
  parameter int unsigned INDEX_BITS = 6,
  parameter int unsigned TAG_BITS   = 8
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic [INDEX_BITS-1:0] rd_idx_a_i,
  output bp_entry_t             rd_entry_a_o,
  input  logic [INDEX_BITS-1:0] rd_idx_b_i,
  output bp_entry_t             rd_entry_b_o,
  input  logic                  wr_en_i,
  input  logic [INDEX_BITS-1:0] wr_idx_i,
  input  bp_entry_t             wr_entry_i
);

  localparam int DEPTH = 1 << INDEX_BITS;

  logic                valid_q  [DEPTH];
  ctr_t                ctr_q    [DEPTH];
  logic [TAG_BITS-1:0] tag_q    [DEPTH];
  logic [31:0]         target_q [DEPTH];

  // Control state: valid bits and counters, cleared by reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= CTR_RESET;
      end
    end else if (wr_en_i) begin
      valid_q[wr_idx_i] <= wr_entry_i.valid;
      ctr_q[wr_idx_i]   <= wr_entry_i.ctr;
    end
  end

  // Payload state: tag and target, written only on training.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      tag_q[wr_idx_i]    <= wr_entry_i.tag[TAG_BITS-1:0];
      target_q[wr_idx_i] <= wr_entry_i.target;
    end
  end

  // Fetch-side read port; returns the pre-write entry on a same-cycle write.
  always_comb begin
    rd_entry_a_o                   = '0;
    rd_entry_a_o.valid             = valid_q[rd_idx_a_i];
    rd_entry_a_o.tag[TAG_BITS-1:0] = tag_q[rd_idx_a_i];
    rd_entry_a_o.target            = target_q[rd_idx_a_i];
    rd_entry_a_o.ctr               = ctr_q[rd_idx_a_i];
  end

  // Decode-side read port used to form the training write.
  always_comb begin
    rd_entry_b_o                   = '0;
    rd_entry_b_o.valid             = valid_q[rd_idx_b_i];
    rd_entry_b_o.tag[TAG_BITS-1:0] = tag_q[rd_idx_b_i];
    rd_entry_b_o.target            = target_q[rd_idx_b_i];
    rd_entry_b_o.ctr               = ctr_q[rd_idx_b_i];
  end

  // Upper tag bits are always zero-extension and carry no information.
  logic unused_wr_tag;
  assign unused_wr_tag = ^wr_entry_i.tag[TAG_MAX-1:TAG_BITS];

endmodule

// File: rtl/branch_predictor.sv
// Dynamic branch predictor: BTB plus 2-bit saturating counters.
// Fetch looks up pcF combinationally; the prediction rides in a D-stage
// register, is scored against the resolved outcome in Decode, and the entry
// is trained once per branch when the D register is valid and not stalled.
// Optional build macro BP_GSHARE_EN: index = pc bits XOR a global history
// register of resolved branch outcomes; the fetch index is carried to Decode
// so training writes the same entry that was read.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int unsigned INDEX_BITS = 6,
  parameter int unsigned TAG_BITS   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pcF,
  input  logic        stallD,
  input  logic        flushD,
  input  logic        branchD,
  input  logic        takenD,
  input  logic [31:0] targetD,
  input  logic [31:0] pcplus4D,
  output logic        predict_takenF,
  output logic [31:0] predict_pcF,
  output logic        predict_miss,
  output logic [31:0] correct_pcD
);

  localparam int unsigned TAG_LO  = INDEX_BITS + 2;
  localparam int unsigned TAG_HI  = INDEX_BITS + TAG_BITS + 1;
  localparam int unsigned TAG_PAD = TAG_MAX - TAG_BITS;

  logic [INDEX_BITS-1:0] idxF;
  logic [INDEX_BITS-1:0] idxD;
  logic [TAG_BITS-1:0]   tagF;
  logic [TAG_BITS-1:0]   tagD;
  bp_entry_t             entF;
  bp_entry_t             entD;
  bp_entry_t             wr_entry;
  logic                  wr_en;
  logic                  hitF;
  logic                  hitD;
  logic                  scoreD;

  logic                  vD_q;
  logic                  vD_d;
  logic                  predtakenD_q;
  logic [31:0]           predpcD_q;
  logic [31:0]           pcD_q;

`ifdef BP_GSHARE_EN
  logic [INDEX_BITS-1:0] ghr_q;
  logic [INDEX_BITS-1:0] ghr_d;
  logic [INDEX_BITS-1:0] idxD_q;
`endif

  bp_table #(
    .INDEX_BITS (INDEX_BITS),
    .TAG_BITS   (TAG_BITS)
  ) u_table (
    .clk_i        (clk),
    .reset_i      (reset),
    .rd_idx_a_i   (idxF),
    .rd_entry_a_o (entF),
    .rd_idx_b_i   (idxD),
    .rd_entry_b_o (entD),
    .wr_en_i      (wr_en),
    .wr_idx_i     (idxD),
    .wr_entry_i   (wr_entry)
  );

  // ---- Fetch stage: combinational lookup ----
  assign tagF = pcF[TAG_HI:TAG_LO];
`ifdef BP_GSHARE_EN
  assign idxF = pcF[INDEX_BITS+1:2] ^ ghr_q;
`else
  assign idxF = pcF[INDEX_BITS+1:2];
`endif

  assign hitF           = entF.valid && (entF.tag == {{TAG_PAD{1'b0}}, tagF});
  assign predict_takenF = hitF && (entF.ctr == WT || entF.ctr == ST);
  assign predict_pcF    = predict_takenF ? entF.target : (pcF + 32'd4);

  // ---- F/D boundary: prediction register ----
  // Valid bit next state: flush beats stall, stall holds, otherwise load.
  always_comb begin
    vD_d = 1'b1;
    if (flushD) begin
      vD_d = 1'b0;
    end else if (stallD) begin
      vD_d = vD_q;
    end
  end

  // Valid bit register; reset abandons whatever sits in Decode.
  always_ff @(posedge clk) begin
    if (reset) begin
      vD_q <= 1'b0;
    end else begin
      vD_q <= vD_d;
    end
  end

  // Prediction payload; its contents only matter while vD_q is set.
  always_ff @(posedge clk) begin
    if (!stallD) begin
      predtakenD_q <= predict_takenF;
      predpcD_q    <= predict_pcF;
      pcD_q        <= pcF;
`ifdef BP_GSHARE_EN
      idxD_q       <= idxF;
`endif
    end
  end

  // ---- Decode stage: scoring and training ----
  assign tagD = pcD_q[TAG_HI:TAG_LO];
`ifdef BP_GSHARE_EN
  assign idxD = idxD_q;
`else
  assign idxD = pcD_q[INDEX_BITS+1:2];
`endif

  assign scoreD = vD_q && !stallD;
  assign hitD   = entD.valid && (entD.tag == {{TAG_PAD{1'b0}}, tagD});

  // Misprediction detection and redirect PC; defaults to the fall-through.
  always_comb begin
    predict_miss = 1'b0;
    correct_pcD  = pcplus4D;
    if (scoreD) begin
      if (branchD) begin
        if (takenD && (!predtakenD_q || (predpcD_q != targetD))) begin
          predict_miss = 1'b1;
          correct_pcD  = targetD;
        end else if (!takenD && predtakenD_q) begin
          predict_miss = 1'b1;
        end
      end else if (predtakenD_q) begin
        predict_miss = 1'b1;
      end
    end
  end

  // Training write: read-modify-write of the Decode entry, one per branch.
  always_comb begin
    wr_en    = 1'b0;
    wr_entry = entD;
    if (scoreD && !reset) begin
      if (branchD) begin
        wr_en = 1'b1;
        if (takenD) begin
          wr_entry.valid  = 1'b1;
          wr_entry.tag    = {{TAG_PAD{1'b0}}, tagD};
          wr_entry.target = targetD;
          wr_entry.ctr    = hitD ? sat_inc(entD.ctr) : CTR_ALLOC;
        end else begin
          wr_entry.ctr    = sat_dec(entD.ctr);
        end
      end else if (predtakenD_q) begin
        wr_en          = 1'b1;
        wr_entry.valid = 1'b0;
      end
    end
  end

`ifdef BP_GSHARE_EN
  // Global history next state: shift in each resolved branch outcome.
  always_comb begin
    ghr_d = ghr_q;
    if (wr_en && branchD) begin
      ghr_d = {ghr_q[INDEX_BITS-2:0], takenD};
    end
  end

  // Global history register.
  always_ff @(posedge clk) begin
    if (reset) begin
      ghr_q <= '0;
    end else begin
      ghr_q <= ghr_d;
    end
  end

  // PC bits outside the tag are not needed once the index is carried along.
  logic unused_pcD;
  assign unused_pcD = ^{pcD_q[31:TAG_HI+1], pcD_q[TAG_LO-1:0]};
`else
  // PC bits outside index and tag play no part in training.
  logic unused_pcD;
  assign unused_pcD = ^{pcD_q[31:TAG_HI+1], pcD_q[1:0]};
`endif

endmodule
